// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that time-shares one serial Mealy '101' detector.
// Each granted word is shifted MSB-first after a detector clear; hits are counted.
module seq_det_scheduler #(
   parameter int NREQ   = 4,
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WORD_W-1:0]   data,
   output logic [NREQ-1:0]          ack,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(NREQ)-1:0]  done_id,
   output logic [CNT_W-1:0]         hit_cnt,
   output logic                     det_x,
   output logic                     det_rst,
   input  logic                     det_z
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

   state_t            state;
   logic [IW-1:0]     last;
   logic [IW-1:0]     gnt;
   logic [WORD_W-1:0] shreg;
   logic [BW-1:0]     bitcnt;

   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     cand;
   int                pos;

   // Scan starts one past the last winner, wrapping at NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      pos       = 0;
      for (int i = 0; i < NREQ; i++) begin
         pos = int'(last) + 1 + i;
         if (pos >= NREQ) pos = pos - NREQ;
         cand = IW'(pos);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         last    <= IW'(NREQ - 1);
         gnt     <= '0;
         shreg   <= '0;
         bitcnt  <= '0;
         hit_cnt <= '0;
         ack     <= '0;
         done    <= 1'b0;
         done_id <= '0;
      end else begin
         ack  <= '0;
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_found) begin
                  shreg   <= data[win_idx*WORD_W +: WORD_W];
                  gnt     <= win_idx;
                  last    <= win_idx;
                  hit_cnt <= '0;
                  state   <= CLR;
               end
            end
            CLR: begin
               bitcnt <= BW'(WORD_W - 1);
               state  <= SHIFT;
            end
            SHIFT: begin
               if (det_z && hit_cnt != CNT_MAX)
                  hit_cnt <= hit_cnt + 1'b1;
               shreg <= {shreg[WORD_W-2:0], 1'b0};
               if (bitcnt == '0) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  ack[gnt]   <= 1'b1;
                  done_id    <= gnt;
               end else begin
                  bitcnt <= bitcnt - 1'b1;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign det_x   = (state == SHIFT) && shreg[WORD_W-1];
   assign det_rst = rst || (state == CLR);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler with a behavioural '101' detector.
// Second instance covers a 16-bit word with a 2-bit saturating counter.
module tb_seq_det_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   logic [3:0]  ack;
   logic        busy, done, det_x, det_rst, det_z;
   logic [1:0]  done_id;
   logic [3:0]  hit_cnt;

   logic [1:0]  req16 = '0;
   logic [31:0] data16 = '0;
   logic [1:0]  ack16;
   logic        busy16, done16, det_x16, det_rst16, det_z16;
   logic        done_id16;
   logic [1:0]  hit_cnt16;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_det_scheduler #(.NREQ(4), .WORD_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
      .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt),
      .det_x(det_x), .det_rst(det_rst), .det_z(det_z)
   );

   seq_det_scheduler #(.NREQ(2), .WORD_W(16), .CNT_W(2)) dut16 (
      .clk(clk), .rst(rst), .req(req16), .data(data16), .ack(ack16),
      .busy(busy16), .done(done16), .done_id(done_id16),
      .hit_cnt(hit_cnt16), .det_x(det_x16), .det_rst(det_rst16),
      .det_z(det_z16)
   );

   // Mealy '101' detector: 0 = idle, 1 = seen 1, 2 = seen 10.
   logic [1:0] ds, ds16;
   function automatic logic [1:0] dnext(input logic [1:0] s, input logic x);
      if (x) return 2'd1;
      return (s == 2'd1) ? 2'd2 : 2'd0;
   endfunction
   always_ff @(posedge clk or posedge det_rst)
      if (det_rst) ds <= 2'd0; else ds <= dnext(ds, det_x);
   always_ff @(posedge clk or posedge det_rst16)
      if (det_rst16) ds16 <= 2'd0; else ds16 <= dnext(ds16, det_x16);
   assign det_z   = (ds == 2'd2) && det_x;
   assign det_z16 = (ds16 == 2'd2) && det_x16;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done !== 1'b1 && n < 40);
      chk("done_seen", done, 1);
   endtask

   task automatic xact(input int idx, input logic [7:0] w,
                       input int hits, input string tag);
      int n;
      logic [3:0] e;
      e = 4'b0001 << idx;
      data[idx*8 +: 8] = w;
      req[idx] = 1'b1;
      wait_done(n);
      chk({tag, "_lat"}, n, 10);
      chk({tag, "_id"}, done_id, idx);
      chk({tag, "_hits"}, hit_cnt, hits);
      chk({tag, "_ack"}, ack, e);
      req[idx] = 1'b0;
      tick();
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int n, prev, prevh;
      logic [7:0] w;
      logic wrap, any_ack;
      int exp_ids[8] = '{0, 1, 2, 3, 1, 3, 1, 3};

      // reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack", ack, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_hit", hit_cnt, 0);
      chk("rst_det_x", det_x, 0);
      chk("rst_det_rst", det_rst, 1);
      tick();
      tick();
      rst = 1'b0;

      // 1: single word, cycle-by-cycle detector drive
      w = 8'b1010_0000;
      data[7:0] = w;
      req = 4'b0001;
      tick();
      chk("t1_clr_busy", busy, 1);
      chk("t1_clr_det_rst", det_rst, 1);
      chk("t1_clr_det_x", det_x, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("t1_det_x%0d", k), det_x, w[7-k]);
         if (k == 0) chk("t1_shift_det_rst", det_rst, 0);
      end
      tick();
      chk("t1_done", done, 1);
      chk("t1_done_id", done_id, 0);
      chk("t1_ack", ack, 4'b0001);
      chk("t1_hits", hit_cnt, 1);
      chk("t1_done_busy", busy, 1);
      chk("t1_done_det_x", det_x, 0);
      req = 4'b0000;
      tick();
      chk("t1_post_done", done, 0);
      chk("t1_post_busy", busy, 0);
      chk("t1_post_ack", ack, 0);
      chk("t1_hit_held", hit_cnt, 1);

      // 2: hit counting, overlapping matches
      xact(1, 8'b1010_1010, 3, "t2_aa");
      xact(2, 8'b1101_1011, 2, "t2_db");
      xact(3, 8'h00, 0, "t2_00");

      // 3: round-robin order and spacing
      do_reset();
      data = {4{8'hA0}};
      req = 4'b1111;
      prev = 0;
      for (int k = 0; k < 8; k++) begin
         wait_done(n);
         if (k == 0) chk("t3_first_lat", n, 10);
         else chk($sformatf("t3_gap%0d", k), cyc - prev, 11);
         prev = cyc;
         chk($sformatf("t3_id%0d", k), done_id, exp_ids[k]);
         chk($sformatf("t3_hit%0d", k), hit_cnt, 1);
         if (k < 3) req[done_id] = 1'b0;
         else if (k == 3) req = 4'b1010;
      end
      req = 4'b0000;
      tick();

      // 4: reset in the middle of SHIFT
      do_reset();
      data[7:0] = 8'hAA;
      req = 4'b0001;
      tick();
      chk("t4_clr_hit", hit_cnt, 0);
      repeat (5) tick();
      chk("t4_bit4_det_x", det_x, 1);
      chk("t4_bit4_hit", hit_cnt, 1);
      rst = 1'b1;
      #1;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_det_rst", det_rst, 1);
      chk("t4_rst_det_x", det_x, 0);
      chk("t4_rst_ack", ack, 0);
      chk("t4_rst_done", done, 0);
      chk("t4_rst_hit", hit_cnt, 0);
      req = 4'b0100;
      data[23:16] = 8'hA0;
      tick();
      rst = 1'b0;
      wait_done(n);
      chk("t4_lat", n, 10);
      chk("t4_id", done_id, 2);
      chk("t4_hits", hit_cnt, 1);
      chk("t4_ack", ack, 4'b0100);
      req = 4'b0000;
      tick();

      // 6: requester drops its request mid-word
      data[7:0] = 8'hAA;
      req = 4'b0001;
      repeat (5) tick();
      req = 4'b0000;
      wait_done(n);
      chk("t6_ack", ack, 4'b0001);
      chk("t6_id", done_id, 0);
      chk("t6_hits", hit_cnt, 3);
      any_ack = 1'b0;
      repeat (15) begin
         tick();
         any_ack = any_ack | (|ack);
      end
      chk("t6_no_spurious_ack", any_ack, 0);
      chk("t6_idle_busy", busy, 0);

      // 5: 16-bit word, counter saturates at 3
      data16 = {16'h0000, 16'hAAAA};
      req16 = 2'b01;
      n = 0;
      prevh = 0;
      wrap = 1'b0;
      do begin
         tick();
         n++;
         if (int'(hit_cnt16) < prevh) wrap = 1'b1;
         prevh = int'(hit_cnt16);
      end while (done16 !== 1'b1 && n < 60);
      chk("t5_done_seen", done16, 1);
      chk("t5_lat", n, 18);
      chk("t5_hits_sat", hit_cnt16, 3);
      chk("t5_no_wrap", wrap, 0);
      chk("t5_id", done_id16, 0);
      chk("t5_ack", ack16, 2'b01);
      req16 = 2'b00;
      tick();
      chk("t5_idle_busy", busy16, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
